// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the demux dispatch sequencer.
package demux_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } dispatch_state_e;

    // Lane-select width; a single lane still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_demux.sv
// Data fan-out: drives data_i onto the selected lane, all other lanes read zero.
module demux_dispatch_ctrl_demux #(
    parameter int DataWidth  = 32,
    parameter int NumOutputs = 8,
    parameter int SelWidth   = 3
) (
    input  logic [SelWidth-1:0]  sel_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] data_o [NumOutputs]
);

    for (genvar gi = 0; gi < NumOutputs; gi++) begin : g_lane
        assign data_o[gi] = (sel_i == SelWidth'(gi)) ? data_i : '0;
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Buffers a {data, dest} stream in a small FIFO and steers the head entry to one
// of NumOutputs independently stalling consumer lanes.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter  int DataWidth  = 32,
    parameter  int NumOutputs = 8,
    parameter  int FifoDepth  = 2,
    parameter  int StallWidth = 16,
    localparam int SelWidth   = sel_width(NumOutputs)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DataWidth-1:0]  in_data_i,
    input  logic [SelWidth-1:0]   in_dest_i,
    output logic [NumOutputs-1:0] out_valid_o,
    input  logic [NumOutputs-1:0] out_ready_i,
    output logic [DataWidth-1:0]  out_data_o [NumOutputs],
    output logic                  busy_o,
    output logic                  err_bad_dest_o,
    output logic [StallWidth-1:0] stall_cnt_o
);

    localparam int IdxWidth = $clog2(FifoDepth);
    localparam int PtrWidth = IdxWidth + 1;
    localparam logic [SelWidth:0] NumOutputsExt = (SelWidth + 1)'(NumOutputs);

    logic [DataWidth-1:0]  data_mem_q [FifoDepth];
    logic [SelWidth-1:0]   dest_mem_q [FifoDepth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    dispatch_state_e       state_q, state_d;
    logic                  err_q, err_d;
    logic [StallWidth-1:0] stall_q, stall_d;

    logic                  full, empty, push, pop;
    logic [DataWidth-1:0]  head_data, send_data;
    logic [SelWidth-1:0]   head_dest, next_head_dest;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PtrWidth-1] != rd_ptr_q[PtrWidth-1]) &&
                       (wr_ptr_q[IdxWidth-1:0] == rd_ptr_q[IdxWidth-1:0]);
    assign head_data = data_mem_q[rd_ptr_q[IdxWidth-1:0]];
    assign head_dest = dest_mem_q[rd_ptr_q[IdxWidth-1:0]];

    // Full refuses a push even when the head pops this cycle; held low in reset.
    assign in_ready_o = !full && !rst_i;
    assign push       = in_valid_i && in_ready_o && !flush_i;
    assign pop        = (|(out_valid_o & out_ready_i)) || (state_q == DROP);

    assign wr_ptr_d = flush_i ? '0 : wr_ptr_q + PtrWidth'(push);
    assign rd_ptr_d = flush_i ? '0 : rd_ptr_q + PtrWidth'(pop && !flush_i);

    // The next head may be the entry being written this very cycle.
    assign next_head_dest = (push && (rd_ptr_d == wr_ptr_q)) ? in_dest_i
                                                             : dest_mem_q[rd_ptr_d[IdxWidth-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem_q[wr_ptr_q[IdxWidth-1:0]] <= in_data_i;
            dest_mem_q[wr_ptr_q[IdxWidth-1:0]] <= in_dest_i;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i || (wr_ptr_d == rd_ptr_d)) begin
            state_d = IDLE;
        end else if ({1'b0, next_head_dest} >= NumOutputsExt) begin
            state_d = DROP;
        end else begin
            state_d = SEND;
        end
    end

    always_comb begin
        out_valid_o = '0;
        send_data   = '0;
        if (state_q == SEND) begin
            out_valid_o[head_dest] = 1'b1;
            send_data              = head_data;
        end
    end

    // Stall counter only advances while a presented head is refused by its lane.
    always_comb begin
        stall_d = '0;
        if (!flush_i && (state_q == SEND) && !pop) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + StallWidth'(1);
        end
    end

    assign err_d          = flush_i ? 1'b0 : (err_q || (state_q == DROP));
    assign busy_o         = !empty;
    assign err_bad_dest_o = err_q;
    assign stall_cnt_o    = stall_q;

    demux_dispatch_ctrl_demux #(
        .DataWidth  (DataWidth),
        .NumOutputs (NumOutputs),
        .SelWidth   (SelWidth)
    ) u_demux (
        .sel_i  (head_dest),
        .data_i (send_data),
        .data_o (out_data_o)
    );

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench: 8-lane instance against a queue model, 5-lane instance for bad-dest drops.
module tb_demux_dispatch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush, in_valid, in_ready, busy, err;
    logic [31:0] in_data;
    logic [2:0]  in_dest;
    logic [7:0]  out_valid, out_ready;
    logic [31:0] out_data [8];
    logic [15:0] stall;

    logic        flush5, in_valid5, in_ready5, busy5, err5;
    logic [31:0] in_data5;
    logic [2:0]  in_dest5;
    logic [4:0]  out_valid5, out_ready5;
    logic [31:0] out_data5 [5];
    logic [15:0] stall5;

    demux_dispatch_ctrl #(
        .DataWidth(32), .NumOutputs(8), .FifoDepth(2), .StallWidth(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_dest_i(in_dest),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .err_bad_dest_o(err), .stall_cnt_o(stall)
    );

    demux_dispatch_ctrl #(
        .DataWidth(32), .NumOutputs(5), .FifoDepth(2), .StallWidth(16)
    ) dut5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush5),
        .in_valid_i(in_valid5), .in_ready_o(in_ready5), .in_data_i(in_data5), .in_dest_i(in_dest5),
        .out_valid_o(out_valid5), .out_ready_i(out_ready5), .out_data_o(out_data5),
        .busy_o(busy5), .err_bad_dest_o(err5), .stall_cnt_o(stall5)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: entries waiting in order, plus the head's wait time.
    typedef struct {
        logic [31:0] data;
        logic [2:0]  dest;
    } ent_t;
    ent_t mq[$];
    int   m_stall = 0;

    // Compare the 8-lane DUT against the model, apply one cycle of stimulus, advance.
    task automatic step(input logic v, input logic [31:0] d, input logic [2:0] dst,
                        input logic [7:0] rdy, input logic fl);
        logic [7:0]  ev;
        logic [31:0] hd;
        int          sz;
        bit          do_pop, do_push;
        ev = '0;
        hd = '0;
        sz = mq.size();
        if (sz > 0) begin
            ev = 8'd1 << mq[0].dest;
            hd = mq[0].data;
        end
        chk("in_ready", in_ready, (sz < 2));
        chk("out_valid", out_valid, ev);
        chk("busy", busy, (sz > 0));
        chk("stall_cnt", stall, 16'(m_stall));
        chk("err", err, 1'b0);
        for (int l = 0; l < 8; l++)
            chk($sformatf("out_data[%0d]", l), out_data[l], ev[l] ? hd : 32'd0);
        in_valid  = v;
        in_data   = d;
        in_dest   = dst;
        out_ready = rdy;
        flush     = fl;
        do_pop  = (sz > 0) && rdy[mq[0].dest];
        do_push = v && (sz < 2);
        if (fl) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (do_pop) begin
                mq.delete(0);
                m_stall = 0;
            end else if (sz > 0) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                m_stall = 0;
            end
            if (do_push) mq.push_back('{data: d, dest: dst});
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] data;
        logic [2:0]  dest;
        logic [7:0]  rdy;
        logic [7:0]  exp_valid;
        logic        exp_busy;
    } vec_t;
    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'h0000_0001, 3'd0, 8'hFF, 8'h01, 1'b0};
        tbl[1] = '{32'hA5A5_A5A5, 3'd7, 8'h80, 8'h80, 1'b0};
        tbl[2] = '{32'h1234_5678, 3'd4, 8'hEF, 8'h10, 1'b1};
        tbl[3] = '{32'hFFFF_FFFF, 3'd2, 8'h04, 8'h04, 1'b0};
        tbl[4] = '{32'h0BAD_F00D, 3'd6, 8'h00, 8'h40, 1'b1};
        tbl[5] = '{32'hCAFE_0001, 3'd1, 8'hFD, 8'h02, 1'b1};

        rst = 1'b1;
        flush = 0; in_valid = 0; in_data = 0; in_dest = 0; out_ready = 0;
        flush5 = 0; in_valid5 = 0; in_data5 = 0; in_dest5 = 0; out_ready5 = 0;
        #1;
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_out_valid", out_valid, 8'h00);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle after reset
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_valid", out_valid, 8'h00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_stall", stall, 16'd0);

        // Single entry to lane 3, popped on first presentation
        step(1'b1, 32'hDEAD_BEEF, 3'd3, 8'h08, 1'b0);
        chk("single_valid", out_valid, 8'b0000_1000);
        chk("single_data", out_data[3], 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 3'd0, 8'h08, 1'b0);
        chk("single_popped", busy, 1'b0);

        // Table of single-entry presentations
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].data, tbl[i].dest, 8'h00, 1'b0);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_data", i), out_data[tbl[i].dest], tbl[i].data);
            step(1'b0, 32'h0, 3'd0, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            step(1'b0, 32'h0, 3'd0, 8'hFF, 1'b0);
        end

        // Lane 5 stalled with two entries queued
        step(1'b1, 32'hAAAA_0001, 3'd5, 8'h00, 1'b0);
        step(1'b1, 32'hAAAA_0002, 3'd5, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 3'd0, 8'hDF, 1'b0);
        chk("stall_full_ready", in_ready, 1'b0);
        chk("stall_cnt10", stall, 16'd10);
        chk("stall_data", out_data[5], 32'hAAAA_0001);
        step(1'b1, 32'hAAAA_0003, 3'd5, 8'h20, 1'b0);
        chk("stall_pop_cnt", stall, 16'd0);
        chk("stall_pop_head", out_data[5], 32'hAAAA_0002);
        step(1'b0, 32'h0, 3'd0, 8'h20, 1'b0);
        chk("stall_no_push_when_full", busy, 1'b0);

        // Back-to-back stream across all lanes
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'hB000_0000 + 32'(k), 3'(k), 8'hFF, 1'b0);
            chk($sformatf("stream%0d_valid", k), out_valid, 8'd1 << k);
            chk($sformatf("stream%0d_ready", k), in_ready, 1'b1);
        end
        step(1'b0, 32'h0, 3'd0, 8'hFF, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
                 ($urandom_range(0, 24) == 0));
        end
        step(1'b0, 32'h0, 3'd0, 8'hFF, 1'b0);
        step(1'b0, 32'h0, 3'd0, 8'hFF, 1'b0);

        // Asynchronous reset mid-SEND
        step(1'b1, 32'h5EED_0006, 3'd6, 8'h00, 1'b0);
        chk("arst_pre_valid", out_valid, 8'h40);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        mq.delete();
        m_stall = 0;
        @(posedge clk);
        #1;
        chk("arst_after_busy", busy, 1'b0);
        chk("arst_after_ready", in_ready, 1'b1);
        step(1'b0, 32'h0, 3'd0, 8'hFF, 1'b0);

        // Five-lane instance: out-of-range dest is dropped and flagged
        in_valid5 = 1'b1; in_data5 = 32'h66; in_dest5 = 3'd6; out_ready5 = 5'h1F;
        @(posedge clk);
        #1;
        chk("drop_valid", out_valid5, 5'b0);
        chk("drop_err_pre", err5, 1'b0);
        chk("drop_busy", busy5, 1'b1);
        in_data5 = 32'h11; in_dest5 = 3'd1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        chk("drop_err", err5, 1'b1);
        chk("drop_next_valid", out_valid5, 5'b00010);
        chk("drop_next_data", out_data5[1], 32'h11);
        @(posedge clk);
        #1;
        chk("drop_drained", busy5, 1'b0);
        chk("drop_err_sticky", err5, 1'b1);
        flush5 = 1'b1; in_valid5 = 1'b1; in_data5 = 32'h77; in_dest5 = 3'd2;
        #1;
        chk("flush_in_ready", in_ready5, 1'b1);
        @(posedge clk);
        #1;
        flush5 = 1'b0; in_valid5 = 1'b0;
        chk("flush_err", err5, 1'b0);
        chk("flush_push_discarded", busy5, 1'b0);
        chk("flush_stall", stall5, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
